osd_pdl_stream_decoder: RTL and testbench

- Parametrised successor to the disk-II simulator's UART receive decoder.
- Consumes the byte stream from the simulator UART receiver and demultiplexes it into OSD screen-memory writes, an OSD exit request, and NUM_PDL paddle values.
- Additions over the previous generation:
  - paddle frames are checksum-protected and committed atomically;
  - the screen path has an explicit write strobe;
  - an inter-byte timeout resynchronises the parser after a lost byte.
- Sits between UARTReceive and the OSD screen RAM / paddle timer logic.

---
 rtl/osd_pdl_stream_decoder.sv | 175 +++++++++++++++++
 tb/tb_osd_pdl_stream_decoder.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/osd_pdl_stream_decoder.sv
// Demultiplexes the simulator UART byte stream into OSD screen writes, an OSD exit
// request and checksum-protected paddle frames, with inter-byte timeout resync.
module osd_pdl_stream_decoder #(
  parameter int NUM_PDL        = 4,
  parameter int ADDR_W         = 10,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                 clk,
  input  logic                 Rst,
  input  logic [7:0]           rx_data,
  input  logic                 rx_valid,
  output logic [ADDR_W-1:0]    scr_addr,
  output logic [7:0]           scr_data,
  output logic                 scr_we,
  output logic                 exit_osd,
  output logic [8*NUM_PDL-1:0] pdl_data,
  output logic                 pdl_update,
  output logic                 frame_err
);

  localparam int IDX_W = (NUM_PDL > 1) ? $clog2(NUM_PDL) : 1;
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PDL - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    ADDR_LO = 3'd0,
    ADDR_HI = 3'd1,
    DATA    = 3'd2,
    PDL     = 3'd3,
    PDL_CK  = 3'd4
  } state_t;

  state_t                 stateReg, stateNext;
  logic [ADDR_W-1:0]      addrReg, addrNext;
  logic                   addrZeroReg, addrZeroNext;
  logic                   wroteReg, wroteNext;
  logic [8*NUM_PDL-1:0]   shadowReg, shadowNext;
  logic [IDX_W-1:0]       idxReg, idxNext;
  logic [7:0]             ckReg, ckNext;
  logic [TO_W-1:0]        toCntReg, toCntNext;
  logic [ADDR_W-1:0]      scrAddrReg, scrAddrNext;
  logic [7:0]             scrDataReg, scrDataNext;
  logic                   scrWeReg, scrWeNext;
  logic                   exitReg, exitNext;
  logic [8*NUM_PDL-1:0]   pdlDataReg, pdlDataNext;
  logic                   updReg, updNext;
  logic                   errReg, errNext;

  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      stateReg    <= ADDR_LO;
      addrReg     <= '0;
      addrZeroReg <= 1'b0;
      wroteReg    <= 1'b0;
      shadowReg   <= '0;
      idxReg      <= '0;
      ckReg       <= '0;
      toCntReg    <= '0;
      scrAddrReg  <= '0;
      scrDataReg  <= '0;
      scrWeReg    <= 1'b0;
      exitReg     <= 1'b0;
      pdlDataReg  <= '0;
      updReg      <= 1'b0;
      errReg      <= 1'b0;
    end else begin
      stateReg    <= stateNext;
      addrReg     <= addrNext;
      addrZeroReg <= addrZeroNext;
      wroteReg    <= wroteNext;
      shadowReg   <= shadowNext;
      idxReg      <= idxNext;
      ckReg       <= ckNext;
      toCntReg    <= toCntNext;
      scrAddrReg  <= scrAddrNext;
      scrDataReg  <= scrDataNext;
      scrWeReg    <= scrWeNext;
      exitReg     <= exitNext;
      pdlDataReg  <= pdlDataNext;
      updReg      <= updNext;
      errReg      <= errNext;
    end
  end

  always_comb begin
    stateNext    = stateReg;
    addrNext     = addrReg;
    addrZeroNext = addrZeroReg;
    wroteNext    = wroteReg;
    shadowNext   = shadowReg;
    idxNext      = idxReg;
    ckNext       = ckReg;
    toCntNext    = toCntReg;
    scrAddrNext  = scrAddrReg;
    scrDataNext  = scrDataReg;
    scrWeNext    = 1'b0;
    exitNext     = 1'b0;
    pdlDataNext  = pdlDataReg;
    updNext      = 1'b0;
    errNext      = 1'b0;

    if (rx_valid) begin
      toCntNext = '0;
      // 0xFF is a paddle-frame sync everywhere except inside the frame itself
      if (rx_data == 8'hFF && stateReg != PDL && stateReg != PDL_CK) begin
        stateNext = PDL;
        idxNext   = '0;
        ckNext    = '0;
      end else begin
        case (stateReg)
          ADDR_LO: begin
            addrNext[7:0] = rx_data;
            stateNext     = ADDR_HI;
          end
          ADDR_HI: begin
            addrNext[ADDR_W-1:8] = rx_data[ADDR_W-9:0];
            addrZeroNext = ({rx_data[ADDR_W-9:0], addrReg[7:0]} == '0);
            wroteNext    = 1'b0;
            stateNext    = DATA;
          end
          DATA: begin
            if (rx_data == 8'h00) begin
              exitNext  = addrZeroReg && !wroteReg;
              stateNext = ADDR_LO;
            end else begin
              scrAddrNext = addrReg;
              scrDataNext = rx_data;
              scrWeNext   = 1'b1;
              addrNext    = addrReg + 1'b1;
              wroteNext   = 1'b1;
            end
          end
          PDL: begin
            shadowNext[8*idxReg +: 8] = rx_data;
            ckNext  = ckReg ^ rx_data;
            idxNext = idxReg + 1'b1;
            if (idxReg == LAST_IDX) stateNext = PDL_CK;
          end
          PDL_CK: begin
            if (rx_data == ckReg) begin
              pdlDataNext = shadowReg;
              updNext     = 1'b1;
            end else begin
              errNext = 1'b1;
            end
            stateNext = ADDR_LO;
          end
          default: stateNext = ADDR_LO;
        endcase
      end
    end else if (stateReg == ADDR_LO) begin
      toCntNext = '0;
    end else if (toCntReg == TO_LAST) begin
      // Lost byte: drop the partial frame and wait for a fresh address/sync
      stateNext  = ADDR_LO;
      errNext    = 1'b1;
      toCntNext  = '0;
      idxNext    = '0;
      ckNext     = '0;
      shadowNext = '0;
    end else begin
      toCntNext = toCntReg + 1'b1;
    end
  end

  assign scr_addr   = scrAddrReg;
  assign scr_data   = scrDataReg;
  assign scr_we     = scrWeReg;
  assign exit_osd   = exitReg;
  assign pdl_data   = pdlDataReg;
  assign pdl_update = updReg;
  assign frame_err  = errReg;

endmodule

// File: tb/tb_osd_pdl_stream_decoder.sv
// Directed bench for osd_pdl_stream_decoder: screen streams, exit, paddle frames, timeout.
module tb_osd_pdl_stream_decoder;

  localparam int NUM_PDL = 4;
  localparam int ADDR_W  = 10;
  localparam int TO_CYC  = 50;

  logic                 clk = 1'b0;
  logic                 Rst;
  logic [7:0]           rx_data;
  logic                 rx_valid;
  logic [ADDR_W-1:0]    scr_addr;
  logic [7:0]           scr_data;
  logic                 scr_we;
  logic                 exit_osd;
  logic [8*NUM_PDL-1:0] pdl_data;
  logic                 pdl_update;
  logic                 frame_err;

  int testsRun = 0;
  int failCount = 0;
  int exitCnt = 0;
  int updCnt = 0;
  int errCnt = 0;
  logic [ADDR_W-1:0] wrAddrQ[$];
  logic [7:0]        wrDataQ[$];

  osd_pdl_stream_decoder #(
    .NUM_PDL(NUM_PDL), .ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TO_CYC)
  ) dut (
    .clk(clk), .Rst(Rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .scr_addr(scr_addr), .scr_data(scr_data), .scr_we(scr_we), .exit_osd(exit_osd),
    .pdl_data(pdl_data), .pdl_update(pdl_update), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  // Pulse monitor, one line per observed transaction
  always @(negedge clk) begin
    if (!Rst) begin
      if (scr_we) begin
        wrAddrQ.push_back(scr_addr);
        wrDataQ.push_back(scr_data);
        $display("[TB] scr write addr=0x%03h data=0x%02h", scr_addr, scr_data);
      end
      if (exit_osd) begin
        exitCnt++;
        $display("[TB] exit_osd pulse");
      end
      if (pdl_update) begin
        updCnt++;
        $display("[TB] pdl_update data=0x%08h", pdl_data);
      end
      if (frame_err) begin
        errCnt++;
        $display("[TB] frame_err pulse");
      end
    end
  end

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    testsRun++;
    if (got !== exp) begin
      failCount++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic sendByte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clearCounts();
    wrAddrQ.delete();
    wrDataQ.delete();
    exitCnt = 0;
    updCnt  = 0;
    errCnt  = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    Rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
    idle(3);
    checkVal("rst_scr_we", scr_we, 0);
    checkVal("rst_scr_addr", scr_addr, 0);
    checkVal("rst_outputs", {scr_data, exit_osd, pdl_update, frame_err}, 0);
    checkVal("rst_pdl_data", pdl_data, 0);
    Rst = 1'b0;
    idle(2);

    // Reset in the middle of a screen stream
    sendByte(8'h20); sendByte(8'h00); sendByte(8'h55); sendByte(8'h56);
    #2 Rst = 1'b1;
    #1;
    checkVal("midrst_outputs", {scr_addr, scr_data, scr_we}, 0);
    @(negedge clk);
    Rst = 1'b0;
    idle(1);
    clearCounts();
    sendByte(8'h10); sendByte(8'h01); sendByte(8'h41); sendByte(8'h00);
    idle(2);
    checkVal("midrst_nwr", wrAddrQ.size(), 1);
    checkVal("midrst_addr", wrAddrQ[0], 10'h110);
    checkVal("midrst_data", wrDataQ[0], 8'h41);
    checkVal("midrst_exit", exitCnt, 0);

    // Address wrap; high byte upper bits ignored (0x07 -> 0x3)
    clearCounts();
    sendByte(8'hFE); sendByte(8'h07); sendByte(8'hAA); sendByte(8'hBB); sendByte(8'hCC);
    sendByte(8'h00);
    idle(2);
    checkVal("wrap_nwr", wrAddrQ.size(), 3);
    checkVal("wrap_a0", {wrAddrQ[0], wrDataQ[0]}, {10'h3FE, 8'hAA});
    checkVal("wrap_a1", {wrAddrQ[1], wrDataQ[1]}, {10'h3FF, 8'hBB});
    checkVal("wrap_a2", {wrAddrQ[2], wrDataQ[2]}, {10'h000, 8'hCC});
    checkVal("wrap_exit", exitCnt, 0);
    checkVal("wrap_hold", {scr_addr, scr_data, scr_we}, {10'h000, 8'hCC, 1'b0});

    // Exit request: address 0, no data
    clearCounts();
    sendByte(8'h00); sendByte(8'h00); sendByte(8'h00);
    checkVal("exit_latency", exit_osd, 1);
    idle(2);
    checkVal("exit_cnt", exitCnt, 1);
    checkVal("exit_nwr", wrAddrQ.size(), 0);
    clearCounts();
    sendByte(8'h00); sendByte(8'h00); sendByte(8'h41); sendByte(8'h00);
    idle(2);
    checkVal("exit_wr", {wrAddrQ.size(), wrAddrQ[0], wrDataQ[0]}, {32'd1, 10'h000, 8'h41});
    checkVal("exit_none", exitCnt, 0);

    // Paddle frame, good checksum then bad checksum
    clearCounts();
    sendByte(8'hFF); sendByte(8'h10); sendByte(8'h20); sendByte(8'h30); sendByte(8'h40);
    sendByte(8'h40);
    checkVal("pdl_upd_latency", pdl_update, 1);
    checkVal("pdl_data_good", pdl_data, 32'h40302010);
    idle(2);
    checkVal("pdl_counts", {updCnt, errCnt}, {32'd1, 32'd0});
    clearCounts();
    sendByte(8'hFF); sendByte(8'h10); sendByte(8'h20); sendByte(8'h30); sendByte(8'h40);
    sendByte(8'h41);
    checkVal("pdl_err_latency", frame_err, 1);
    idle(2);
    checkVal("pdl_bad_held", pdl_data, 32'h40302010);
    checkVal("pdl_bad_counts", {updCnt, errCnt}, {32'd0, 32'd1});

    // 0xFF is ordinary data inside a paddle frame
    clearCounts();
    sendByte(8'hFF); sendByte(8'hFF); sendByte(8'h01); sendByte(8'h02); sendByte(8'h03);
    sendByte(8'hFF);
    idle(2);
    checkVal("pdl_ff_data", pdl_data, 32'h030201FF);
    checkVal("pdl_ff_upd", updCnt, 1);

    // Paddle frame interrupting a screen stream
    clearCounts();
    sendByte(8'h00); sendByte(8'h00); sendByte(8'h41);
    sendByte(8'hFF); sendByte(8'h01); sendByte(8'h02); sendByte(8'h03); sendByte(8'h04);
    sendByte(8'h04);
    idle(2);
    checkVal("osdpdl_nwr", wrAddrQ.size(), 1);
    checkVal("osdpdl_data", pdl_data, 32'h04030201);
    checkVal("osdpdl_pulses", {exitCnt, updCnt, errCnt}, {32'd0, 32'd1, 32'd0});
    clearCounts();
    sendByte(8'h05); sendByte(8'h00); sendByte(8'h77); sendByte(8'h00);
    idle(2);
    checkVal("osdpdl_next", {wrAddrQ.size(), wrAddrQ[0], wrDataQ[0]}, {32'd1, 10'h005, 8'h77});

    // Timeout inside a paddle frame
    clearCounts();
    sendByte(8'hFF); sendByte(8'h11);
    idle(TO_CYC - 1);
    checkVal("to_not_yet", frame_err, 0);
    idle(1);
    checkVal("to_fire", frame_err, 1);
    idle(2);
    checkVal("to_cnt", errCnt, 1);
    checkVal("to_pdl_held", pdl_data, 32'h04030201);
    clearCounts();
    sendByte(8'h06); sendByte(8'h00); sendByte(8'h66); sendByte(8'h00);
    idle(2);
    checkVal("to_resync", {wrAddrQ.size(), wrAddrQ[0]}, {32'd1, 10'h006});

    // Byte arriving on the cycle the timeout would fire wins
    clearCounts();
    sendByte(8'hFF); sendByte(8'h11);
    idle(TO_CYC - 1);
    sendByte(8'h22);
    checkVal("to_race_noerr", frame_err, 0);
    sendByte(8'h33); sendByte(8'h44); sendByte(8'h44);
    idle(2);
    checkVal("to_race_counts", {updCnt, errCnt}, {32'd1, 32'd0});
    checkVal("to_race_data", pdl_data, 32'h44332211);

    // Timeout inside a screen stream keeps issued writes
    clearCounts();
    sendByte(8'h00); sendByte(8'h00); sendByte(8'h41);
    idle(TO_CYC + 5);
    checkVal("to_data_err", errCnt, 1);
    sendByte(8'h02); sendByte(8'h00); sendByte(8'h55); sendByte(8'h00);
    idle(2);
    checkVal("to_data_wr", {wrAddrQ.size(), wrAddrQ[1], wrDataQ[1]}, {32'd2, 10'h002, 8'h55});
    checkVal("to_data_exit", exitCnt, 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
